// File: rtl/io_interconnect_if.sv
// Bus bundles for io_interconnect.
//   io_req_if: per-core request ports plus the broadcast response.
//              Modport master = core side, slave = interconnect side.
//   io_dev_if: the single memory-mapped device bus.
//              Modport master = interconnect side, slave = device side.
//
// Handshake semantics: a core raises req_valid with req_store/req_thread/
// req_address/req_data stable; the transfer happens in the cycle where its
// req_ready bit is high (combinational, one-hot, IDLE only). The device sees
// exactly one of io_write_en/io_read_en high for the whole access with
// address/data stable, and completes in the cycle io_ready=1. rsp_valid is a
// single-cycle strobe; rsp_* fields are only meaningful while it is high.

interface io_req_if #(
    parameter int NUM_REQUESTERS   = 4,
    parameter int THREAD_IDX_WIDTH = 2
);
    localparam int CW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [NUM_REQUESTERS-1:0]                  req_valid;
    logic [NUM_REQUESTERS-1:0]                  req_store;
    logic [NUM_REQUESTERS*THREAD_IDX_WIDTH-1:0] req_thread;
    logic [NUM_REQUESTERS*32-1:0]               req_address;
    logic [NUM_REQUESTERS*32-1:0]               req_data;
    logic [NUM_REQUESTERS-1:0]                  req_ready;
    logic                                       rsp_valid;
    logic [CW-1:0]                              rsp_core;
    logic [THREAD_IDX_WIDTH-1:0]                rsp_thread;
    logic                                       rsp_store;
    logic                                       rsp_error;
    logic [31:0]                                rsp_read_value;

    modport master (
        output req_valid, req_store, req_thread, req_address, req_data,
        input  req_ready, rsp_valid, rsp_core, rsp_thread, rsp_store,
               rsp_error, rsp_read_value
    );

    modport slave (
        input  req_valid, req_store, req_thread, req_address, req_data,
        output req_ready, rsp_valid, rsp_core, rsp_thread, rsp_store,
               rsp_error, rsp_read_value
    );
endinterface

interface io_dev_if;
    logic        io_write_en;
    logic        io_read_en;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    modport master (
        output io_write_en, io_read_en, io_address, io_write_data,
        input  io_read_data, io_ready
    );

    modport slave (
        input  io_write_en, io_read_en, io_address, io_write_data,
        output io_read_data, io_ready
    );
endinterface

// File: rtl/io_interconnect.sv
// Round-robin non-cacheable I/O arbiter: NUM_REQUESTERS cores share one
// device bus. One access at a time walks IDLE -> ACCESS -> RESPOND.
// Device wait states are taken from io_ready; an access left waiting for
// TIMEOUT_CYCLES strobe cycles completes with rsp_error=1 (0 disables it).
// dbg_state exposes the FSM: 0=IDLE, 1=ACCESS, 2=RESPOND.

module io_interconnect #(
    parameter int NUM_REQUESTERS   = 4,
    parameter int THREAD_IDX_WIDTH = 2,
    parameter int TIMEOUT_CYCLES   = 256,
    localparam int CW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    io_req_if.slave       core,
    io_dev_if.master      dev,
    output logic [1:0]    dbg_state,
    output logic [CW-1:0] dbg_rr_ptr
);

    localparam int TW  = THREAD_IDX_WIDTH;
    localparam int TOW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // Counter value seen in the last permitted strobe cycle.
    localparam logic [TOW-1:0] TO_LAST = TOW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  rr_ptr;
    logic [TOW-1:0] to_cnt;

    // Request captured at grant time.
    logic           lat_store;
    logic [TW-1:0]  lat_thread;
    logic [CW-1:0]  lat_core;

    // Registered device-side outputs.
    logic           write_en_q;
    logic           read_en_q;
    logic [31:0]    address_q;
    logic [31:0]    write_data_q;

    // Registered response outputs.
    logic           rsp_valid_q;
    logic [CW-1:0]  rsp_core_q;
    logic [TW-1:0]  rsp_thread_q;
    logic           rsp_store_q;
    logic           rsp_error_q;
    logic [31:0]    rsp_read_value_q;

    // Per-core request fields unpacked so the winner can be selected by index.
    logic           store_a   [NUM_REQUESTERS];
    logic [TW-1:0]  thread_a  [NUM_REQUESTERS];
    logic [31:0]    address_a [NUM_REQUESTERS];
    logic [31:0]    data_a    [NUM_REQUESTERS];

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
        assign store_a[i]   = core.req_store[i];
        assign thread_a[i]  = core.req_thread[i*TW +: TW];
        assign address_a[i] = core.req_address[i*32 +: 32];
        assign data_a[i]    = core.req_data[i*32 +: 32];
    end

    // Arbitration result for the current cycle.
    logic                      grant_found;
    logic [CW-1:0]             grant_idx;
    logic [CW-1:0]             grant_next_ptr;
    logic [NUM_REQUESTERS-1:0] grant_onehot;

    // Round-robin search: first valid core at or after rr_ptr, wrapping.
    always_comb begin
        logic [CW:0]   sum;
        logic [CW-1:0] idx_c;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        idx_c       = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (sum >= (CW+1)'(NUM_REQUESTERS)) begin
                sum = sum - (CW+1)'(NUM_REQUESTERS);
            end
            idx_c = sum[CW-1:0];
            if (!grant_found && core.req_valid[idx_c]) begin
                grant_found = 1'b1;
                grant_idx   = idx_c;
            end
        end
        grant_next_ptr = (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + CW'(1);
    end

    // One-hot accept strobe, only while idle and out of reset.
    always_comb begin
        grant_onehot = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            grant_onehot[k] = (state == ST_IDLE) && !reset && grant_found &&
                              (grant_idx == CW'(k));
        end
    end

    // Completion decision for the current ACCESS cycle; io_ready wins over expiry.
    logic        acc_timeout;
    logic        acc_done;
    logic [31:0] acc_value;

    always_comb begin
        acc_timeout = TO_EN && !dev.io_ready && (to_cnt == TO_LAST);
        acc_done    = dev.io_ready || acc_timeout;
        acc_value   = (dev.io_ready && !lat_store) ? dev.io_read_data : 32'd0;
    end

    // Main FSM with registered device strobes and response fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            rr_ptr           <= '0;
            to_cnt           <= '0;
            lat_store        <= 1'b0;
            lat_thread       <= '0;
            lat_core         <= '0;
            write_en_q       <= 1'b0;
            read_en_q        <= 1'b0;
            address_q        <= '0;
            write_data_q     <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_core_q       <= '0;
            rsp_thread_q     <= '0;
            rsp_store_q      <= 1'b0;
            rsp_error_q      <= 1'b0;
            rsp_read_value_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        lat_store    <= store_a[grant_idx];
                        lat_thread   <= thread_a[grant_idx];
                        lat_core     <= grant_idx;
                        address_q    <= address_a[grant_idx];
                        write_data_q <= data_a[grant_idx];
                        write_en_q   <= store_a[grant_idx];
                        read_en_q    <= !store_a[grant_idx];
                        to_cnt       <= '0;
                        rr_ptr       <= grant_next_ptr;
                        state        <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (acc_done) begin
                        write_en_q       <= 1'b0;
                        read_en_q        <= 1'b0;
                        rsp_valid_q      <= 1'b1;
                        rsp_core_q       <= lat_core;
                        rsp_thread_q     <= lat_thread;
                        rsp_store_q      <= lat_store;
                        rsp_error_q      <= !dev.io_ready;
                        rsp_read_value_q <= acc_value;
                        state            <= ST_RESPOND;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                ST_RESPOND: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core.req_ready      = grant_onehot;
    assign core.rsp_valid      = rsp_valid_q;
    assign core.rsp_core       = rsp_core_q;
    assign core.rsp_thread     = rsp_thread_q;
    assign core.rsp_store      = rsp_store_q;
    assign core.rsp_error      = rsp_error_q;
    assign core.rsp_read_value = rsp_read_value_q;

    assign dev.io_write_en   = write_en_q;
    assign dev.io_read_en    = read_en_q;
    assign dev.io_address    = address_q;
    assign dev.io_write_data = write_data_q;

    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule
